// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel receiver: FSM states, colour packing
// order {B,G,R} and the row address width.
package hub75_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned RGB_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH,
      ST_DISPLAY
   } hub_state_e;

   typedef struct packed {
      logic b;
      logic g;
      logic r;
   } rgb_t;

   function automatic rgb_t pack_rgb(input logic r, input logic g, input logic b);
      rgb_t p;
      p.r = r;
      p.g = g;
      p.b = b;
      return p;
   endfunction

endpackage

// File: rtl/hub75_edge_sync.sv
// Multi-stage synchronizer with rise/fall detection taken from the last two
// stages; q_o is the newer of those two so data and edges stay aligned.
module hub75_edge_sync #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= {WIDTH{RST_VAL}};
      end else begin
         sync_q[0] <= d_i;
         for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o    = sync_q[STAGES-2];
   assign rise_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];
   assign fall_o = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/hub75_panel_receiver.sv
// HUB75 receiver: deserialises one row per latch into a valid/ready holding
// register, measures output-enable on-time and flags protocol errors.
module hub75_panel_receiver
   import hub75_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH = 32,
   parameter int unsigned SCREEN_DEPTH = 16,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            hub_clk,
   input  logic                            hub_lat,
   input  logic                            hub_oe_n,
   input  logic                            hub_r1,
   input  logic                            hub_g1,
   input  logic                            hub_b1,
   input  logic                            hub_r2,
   input  logic                            hub_g2,
   input  logic                            hub_b2,
   input  logic [ADDR_W-1:0]               hub_addr,
   output logic                            row_valid,
   input  logic                            row_ready,
   output logic [ADDR_W-1:0]               row_addr,
   output logic [RGB_W*SCREEN_WIDTH-1:0]   row_top,
   output logic [RGB_W*SCREEN_WIDTH-1:0]   row_bot,
   output logic [15:0]                     on_cycles,
   output logic                            on_valid,
   output logic                            err_count,
   output logic                            err_overrun,
   output logic                            err_overlap,
   output logic                            err_addr
);

   localparam int unsigned ROW_W  = RGB_W * SCREEN_WIDTH;
   localparam int unsigned COL_W  = $clog2(SCREEN_WIDTH + 1);
   localparam int unsigned DATA_W = 2 * RGB_W + ADDR_W;

   logic clk_rise, lat_rise, oe_rise, oe_fall, oe_s;
   logic clk_q_unused, clk_fall_unused, lat_q_unused, lat_fall_unused;
   logic [DATA_W-1:0] data_s, data_rise_unused, data_fall_unused;

   hub75_edge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
      .clk_i(clk_in), .rst_i(rst_in), .d_i(hub_clk),
      .q_o(clk_q_unused), .rise_o(clk_rise), .fall_o(clk_fall_unused));

   hub75_edge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lat (
      .clk_i(clk_in), .rst_i(rst_in), .d_i(hub_lat),
      .q_o(lat_q_unused), .rise_o(lat_rise), .fall_o(lat_fall_unused));

   hub75_edge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_oe (
      .clk_i(clk_in), .rst_i(rst_in), .d_i(hub_oe_n),
      .q_o(oe_s), .rise_o(oe_rise), .fall_o(oe_fall));

   hub75_edge_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
      .clk_i(clk_in), .rst_i(rst_in),
      .d_i({hub_addr, hub_b2, hub_g2, hub_r2, hub_b1, hub_g1, hub_r1}),
      .q_o(data_s), .rise_o(data_rise_unused), .fall_o(data_fall_unused));

   rgb_t              rgb_top, rgb_bot;
   logic [ADDR_W-1:0] addr_s;

   assign rgb_top = pack_rgb(data_s[0], data_s[1], data_s[2]);
   assign rgb_bot = pack_rgb(data_s[3], data_s[4], data_s[5]);
   assign addr_s  = data_s[2*RGB_W +: ADDR_W];

   hub_state_e        state_q;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  top_q, top_d, bot_q, bot_d;
   logic [ROW_W-1:0]  rtop_q, rtop_d, rbot_q, rbot_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              rvalid_q, rvalid_d;
   logic [15:0]       oe_cnt_q, oe_cnt_d, on_cyc_q, on_cyc_d;
   logic              on_valid_q, on_valid_d;
   logic              e_cnt_q, e_cnt_d, e_ovr_q, e_ovr_d, e_olap_q, e_olap_d, e_addr_q, e_addr_d;

   always_comb begin
      col_d      = col_q;
      top_d      = top_q;
      bot_d      = bot_q;
      rtop_d     = rtop_q;
      rbot_d     = rbot_q;
      raddr_d    = raddr_q;
      rvalid_d   = rvalid_q;
      oe_cnt_d   = oe_cnt_q;
      on_cyc_d   = on_cyc_q;
      on_valid_d = 1'b0;
      e_cnt_d    = e_cnt_q;
      e_ovr_d    = e_ovr_q;
      e_olap_d   = e_olap_q;
      e_addr_d   = e_addr_q;

      // The shift edge is applied before the latch so a coincident bit lands in the row.
      if (clk_rise) begin
         if (col_q == COL_W'(SCREEN_WIDTH)) begin
            e_cnt_d = 1'b1;
         end else begin
            for (int unsigned c = 0; c < SCREEN_WIDTH; c++) begin
               if (col_q == COL_W'(c)) begin
                  top_d[RGB_W*c +: RGB_W] = rgb_top;
                  bot_d[RGB_W*c +: RGB_W] = rgb_bot;
               end
            end
            col_d = col_q + 1'b1;
         end
         if (!oe_s) e_olap_d = 1'b1;
      end

      if (rvalid_q && row_ready) rvalid_d = 1'b0;

      if (lat_rise) begin
         if (col_d != COL_W'(SCREEN_WIDTH)) e_cnt_d = 1'b1;
         if (rvalid_q && !row_ready) e_ovr_d = 1'b1;
         if (32'(addr_s) >= SCREEN_DEPTH) e_addr_d = 1'b1;
         if (!oe_s) e_olap_d = 1'b1;
         rtop_d   = top_d;
         rbot_d   = bot_d;
         raddr_d  = addr_s;
         rvalid_d = 1'b1;
         top_d    = '0;
         bot_d    = '0;
         col_d    = '0;
      end

      if (!oe_s && oe_cnt_q != 16'hFFFF) oe_cnt_d = oe_cnt_q + 16'd1;
      if (oe_rise) begin
         on_cyc_d   = oe_cnt_q;
         on_valid_d = 1'b1;
         oe_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         col_q      <= '0;
         top_q      <= '0;
         bot_q      <= '0;
         rtop_q     <= '0;
         rbot_q     <= '0;
         raddr_q    <= '0;
         rvalid_q   <= 1'b0;
         oe_cnt_q   <= '0;
         on_cyc_q   <= '0;
         on_valid_q <= 1'b0;
         e_cnt_q    <= 1'b0;
         e_ovr_q    <= 1'b0;
         e_olap_q   <= 1'b0;
         e_addr_q   <= 1'b0;
      end else begin
         col_q      <= col_d;
         top_q      <= top_d;
         bot_q      <= bot_d;
         rtop_q     <= rtop_d;
         rbot_q     <= rbot_d;
         raddr_q    <= raddr_d;
         rvalid_q   <= rvalid_d;
         oe_cnt_q   <= oe_cnt_d;
         on_cyc_q   <= on_cyc_d;
         on_valid_q <= on_valid_d;
         e_cnt_q    <= e_cnt_d;
         e_ovr_q    <= e_ovr_d;
         e_olap_q   <= e_olap_d;
         e_addr_q   <= e_addr_d;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (clk_rise) state_q <= lat_rise ? ST_LATCH : ST_SHIFT;
            ST_SHIFT:   if (lat_rise) state_q <= ST_LATCH;
            ST_LATCH:   if (clk_rise) state_q <= ST_SHIFT;
                        else if (oe_fall) state_q <= ST_DISPLAY;
            ST_DISPLAY: if (clk_rise) state_q <= lat_rise ? ST_LATCH : ST_SHIFT;
            default:    state_q <= ST_IDLE;
         endcase
      end
   end

   assign row_valid   = rvalid_q;
   assign row_addr    = raddr_q;
   assign row_top     = rtop_q;
   assign row_bot     = rbot_q;
   assign on_cycles   = on_cyc_q;
   assign on_valid    = on_valid_q;
   assign err_count   = e_cnt_q;
   assign err_overrun = e_ovr_q;
   assign err_overlap = e_olap_q;
   assign err_addr    = e_addr_q;

endmodule

// File: tb/tb_hub75_panel_receiver.sv
// Scoreboard bench for hub75_panel_receiver: column-queue reference model
// feeds expected rows and on-times; a monitor compares on every handshake.
module tb_hub75_panel_receiver;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 16;

   logic            clk_in = 1'b0;
   logic            rst_in = 1'b1;
   logic            hub_clk = 1'b0, hub_lat = 1'b0, hub_oe_n = 1'b1;
   logic            hub_r1 = 1'b0, hub_g1 = 1'b0, hub_b1 = 1'b0;
   logic            hub_r2 = 1'b0, hub_g2 = 1'b0, hub_b2 = 1'b0;
   logic [4:0]      hub_addr = '0;
   logic            row_ready = 1'b1;
   logic            row_valid, on_valid;
   logic [4:0]      row_addr;
   logic [3*W-1:0]  row_top, row_bot;
   logic [15:0]     on_cycles;
   logic            err_count, err_overrun, err_overlap, err_addr;

   always #5 clk_in = ~clk_in;

   hub75_panel_receiver #(
      .SCREEN_WIDTH(W), .SCREEN_DEPTH(DEPTH), .SYNC_STAGES(2)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
      .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
      .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
      .hub_addr(hub_addr),
      .row_valid(row_valid), .row_ready(row_ready), .row_addr(row_addr),
      .row_top(row_top), .row_bot(row_bot),
      .on_cycles(on_cycles), .on_valid(on_valid),
      .err_count(err_count), .err_overrun(err_overrun),
      .err_overlap(err_overlap), .err_addr(err_addr)
   );

   typedef struct {
      logic [4:0]     addr;
      logic [3*W-1:0] top;
      logic [3*W-1:0] bot;
   } row_t;

   row_t        exp_rows[$];
   int unsigned exp_on[$];
   logic [2:0]  col_top[$], col_bot[$];
   bit          m_count, m_overrun, m_overlap, m_addr;
   int          total = 0, bad = 0;
   int          rows_seen = 0, rows_expected = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Reference model: columns are remembered in arrival order; a row is just
   // the first W of them, anything missing reads as zero.
   task automatic model_latch(input bit overwrite);
      row_t e;
      e.addr = hub_addr;
      e.top  = '0;
      e.bot  = '0;
      for (int c = 0; c < col_top.size() && c < W; c++) begin
         e.top[3*c +: 3] = col_top[c];
         e.bot[3*c +: 3] = col_bot[c];
      end
      if (col_top.size() != W) m_count = 1'b1;
      if (hub_addr >= DEPTH) m_addr = 1'b1;
      if (!hub_oe_n) m_overlap = 1'b1;
      if (overwrite) begin
         m_overrun = 1'b1;
         void'(exp_rows.pop_back());
         rows_expected--;
      end
      exp_rows.push_back(e);
      rows_expected++;
      col_top.delete();
      col_bot.delete();
   endtask

   task automatic set_bits(input logic [2:0] t, input logic [2:0] b);
      {hub_b1, hub_g1, hub_r1} = t;
      {hub_b2, hub_g2, hub_r2} = b;
   endtask

   task automatic shift_col(input logic [2:0] t, input logic [2:0] b);
      if (col_top.size() >= W) m_count = 1'b1;
      if (!hub_oe_n) m_overlap = 1'b1;
      col_top.push_back(t);
      col_bot.push_back(b);
      hub_clk = 1'b0;
      set_bits(t, b);
      tick(2);
      hub_clk = 1'b1;
      tick(2);
      hub_clk = 1'b0;
   endtask

   task automatic latch(input bit overwrite);
      model_latch(overwrite);
      hub_lat = 1'b1;
      tick(2);
      hub_lat = 1'b0;
      tick(4);
   endtask

   task automatic shift_and_latch(input logic [2:0] t, input logic [2:0] b);
      col_top.push_back(t);
      col_bot.push_back(b);
      model_latch(1'b0);
      hub_clk = 1'b0;
      set_bits(t, b);
      tick(2);
      hub_clk = 1'b1;
      hub_lat = 1'b1;
      tick(2);
      hub_clk = 1'b0;
      hub_lat = 1'b0;
      tick(4);
   endtask

   task automatic random_cols(input int n);
      for (int i = 0; i < n; i++) shift_col(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      tick(3);
      rst_in = 1'b0;
      m_count = 0; m_overrun = 0; m_overlap = 0; m_addr = 0;
      col_top.delete();
      col_bot.delete();
      tick(3);
   endtask

   task automatic check_flags(input string tag);
      check({tag, ".err_count"},   err_count,   m_count);
      check({tag, ".err_overrun"}, err_overrun, m_overrun);
      check({tag, ".err_overlap"}, err_overlap, m_overlap);
      check({tag, ".err_addr"},    err_addr,    m_addr);
   endtask

   task automatic end_scenario(input string tag);
      tick(10);
      check({tag, ".rows"}, rows_seen, rows_expected);
      check({tag, ".pending"}, exp_rows.size(), 0);
      check_flags(tag);
   endtask

   row_t        mon_row;
   int unsigned mon_on;

   always @(negedge clk_in) begin
      if (!rst_in && row_valid && row_ready) begin
         rows_seen++;
         if (exp_rows.size() == 0) begin
            total++;
            bad++;
            $display("FAIL row_unexpected: got addr=%0d top=%0h, required no row", row_addr, row_top);
         end else begin
            mon_row = exp_rows.pop_front();
            check("row_addr", row_addr, mon_row.addr);
            check("row_top",  row_top,  mon_row.top);
            check("row_bot",  row_bot,  mon_row.bot);
         end
      end
      if (!rst_in && on_valid) begin
         total++;
         if (exp_on.size() == 0) begin
            bad++;
            $display("FAIL on_unexpected: got on_cycles=%0d, required no pulse", on_cycles);
         end else begin
            mon_on = exp_on.pop_front();
            if (int'(on_cycles) > int'(mon_on) + 1 || int'(on_cycles) + 1 < int'(mon_on)) begin
               bad++;
               $display("FAIL on_cycles: got %0d, required %0d +-1", on_cycles, mon_on);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick(2);
      check("rst.row_valid", row_valid, 1'b0);
      check("rst.on_valid",  on_valid,  1'b0);
      check("rst.on_cycles", on_cycles, 16'd0);
      check("rst.row_top",   row_top,   '0);
      check_flags("rst");
      do_reset();

      // Single marked pixel per half at address 3.
      hub_addr = 5'd3;
      for (int c = 0; c < W; c++)
         shift_col((c == 0) ? 3'b001 : 3'b000, (c == 1) ? 3'b010 : 3'b000);
      latch(1'b0);
      end_scenario("basic");

      for (int k = 0; k < 4; k++) begin
         hub_addr = 5'($urandom_range(0, DEPTH - 1));
         random_cols(W);
         latch(1'b0);
      end
      end_scenario("random");

      hub_addr = 5'd7;
      random_cols(W - 1);
      latch(1'b0);
      end_scenario("short");
      do_reset();

      hub_addr = 5'd9;
      random_cols(W + 1);
      latch(1'b0);
      end_scenario("long");
      do_reset();

      hub_addr = 5'd5;
      random_cols(W - 1);
      shift_and_latch(3'b111, 3'b101);
      end_scenario("coincident");

      row_ready = 1'b0;
      hub_addr = 5'd1;
      random_cols(W);
      latch(1'b0);
      hub_addr = 5'd2;
      random_cols(W);
      latch(1'b1);
      tick(5);
      check_flags("overrun_pending");
      check("overrun.row_valid", row_valid, 1'b1);
      row_ready = 1'b1;
      end_scenario("overrun");
      do_reset();

      hub_addr = 5'd4;
      random_cols(W);
      latch(1'b0);
      exp_on.push_back(33 * 4);
      hub_oe_n = 1'b0;
      tick(33 * 4);
      hub_oe_n = 1'b1;
      tick(6);
      end_scenario("ontime");
      exp_on.push_back(12);
      hub_oe_n = 1'b0;
      tick(4);
      shift_col(3'b001, 3'b001);
      tick(4);
      hub_oe_n = 1'b1;
      tick(6);
      end_scenario("overlap");
      do_reset();

      hub_addr = 5'd6;
      random_cols(10);
      do_reset();
      random_cols(W);
      latch(1'b0);
      end_scenario("midreset");

      hub_addr = 5'd20;
      random_cols(W);
      latch(1'b0);
      end_scenario("badaddr");
      do_reset();

      for (int i = 0; i < 50 && (exp_rows.size() != 0 || exp_on.size() != 0); i++) tick(1);
      check("final.rows_left", exp_rows.size(), 0);
      check("final.on_left",   exp_on.size(),   0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hub75_panel_receiver.md
HUB75_PANEL_RECEIVER -- requirements
Module: hub75_panel_receiver

Interface
REQ-001 Parameter SCREEN_WIDTH, default 32: columns per row, i.e. shift clocks per row load.
REQ-002 Parameter SCREEN_DEPTH, default 16: rows per half-panel; legal address range is 0..SCREEN_DEPTH-1.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on every HUB75 input.
REQ-004 clk_in  input  1  sole clock; at least 4x the HUB75 shift clock frequency.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 hub_clk, hub_lat, hub_oe_n  input  1 each  HUB75 shift clock, latch, and active-low output enable.
REQ-007 hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2  input  1 each  top-half and bottom-half serial colour data.
REQ-008 hub_addr  input  5  row address {E,D,C,B,A}.
REQ-009 row_valid  output  1  captured row available.
REQ-010 row_ready  input  1  consumer accepts the row.
REQ-011 row_addr  output  5  address captured with the row.
REQ-012 row_top, row_bot  output  3*SCREEN_WIDTH each  column c occupies bits [3c+2:3c] = {B,G,R}.
REQ-013 on_cycles  output  16  length in clk_in cycles of the last hub_oe_n-low interval; on_valid  output  1  one-cycle pulse when on_cycles updates.
REQ-014 err_count, err_overrun, err_overlap, err_addr  output  1 each  sticky error flags.

Function
REQ-015 All hub_* inputs shall pass through SYNC_STAGES flops; every detected edge shall be taken from the last two synchronized stages.
REQ-016 A hub_clk rising edge shall sample the synchronized colour bits into column index col, where col is 0 for the first edge after a latch or after reset; col shall then increment and saturate at SCREEN_WIDTH.
REQ-017 A hub_clk rising edge with col==SCREEN_WIDTH shall drop the data and set err_count.
REQ-018 FSM states: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE->SHIFT on the first hub_clk rise.
- SHIFT->LATCH on a hub_lat rise.
- LATCH->DISPLAY on a hub_oe_n fall.
- DISPLAY->SHIFT on a hub_clk rise.
- LATCH->SHIFT on a hub_clk rise (row not displayed).
REQ-019 On a hub_lat rise, the shift buffers and synchronized hub_addr shall be copied to the holding registers; col shall clear to 0.
REQ-020 On a hub_lat rise with col!=SCREEN_WIDTH, the module shall set err_count and still deliver the row; unwritten columns shall be 0.
REQ-021 On a hub_lat rise with hub_addr>=SCREEN_DEPTH, the module shall set err_addr and still deliver the row.
REQ-022 row_valid shall assert in the cycle after the latch edge is detected.
REQ-023 row_valid shall hold, with row_addr/row_top/row_bot stable, until row_valid&&row_ready.
REQ-024 A new latch while row_valid is high and unaccepted shall overwrite the holding registers and set err_overrun.
REQ-025 A new latch in the same cycle as acceptance shall not set err_overrun; row_valid shall remain high carrying the new row.
REQ-026 While hub_oe_n is low, a 16-bit counter shall increment and saturate at 0xFFFF.
REQ-027 On the hub_oe_n rise, the module shall load on_cycles and pulse on_valid for one cycle.
REQ-028 A hub_clk rise or hub_lat rise while hub_oe_n is low shall set err_overlap.
REQ-029 Simultaneous hub_clk and hub_lat rises: the clock edge shall be processed first, so its bit is included in the latched row.
REQ-030 Error flags shall clear only on reset.

Reset
REQ-031 rst_in high shall immediately force:
- state IDLE;
- col 0;
- shift buffers, holding registers and synchronizers all-zero;
- hub_oe_n synchronizer stages to 1;
- row_valid, on_valid and all err_* to 0;
- on_cycles to 0.
REQ-032 Reset asserted mid-row shall discard the partial row, with no row_valid after release.
REQ-033 After reset release, the first hub_clk rise shall be treated as column 0.

Structure
REQ-034 A shared package hub75_pkg shall hold the FSM state encoding, the colour bit order {B,G,R}, and the address width (5).
REQ-035 One sub-module, hub75_edge_sync, shall provide SYNC_STAGES synchronization plus rise/fall pulses; it shall be instantiated per control line (hub_clk, hub_lat, hub_oe_n) and for the data/address bits.

Verification
REQ-036 Bench: 32 clocks, top pattern R at column 0 only, bottom G at column 1, addr=3, latch, row_ready=1 -> one row_valid with row_addr=3, row_top=0x...001, row_bot=0x...010, all err=0.
REQ-037 Bench: 31 clocks, then latch -> row delivered with column 31=0 and err_count=1; 33 clocks -> extra bit dropped and err_count=1.
REQ-038 Bench: row_ready=0, two complete rows latched -> err_overrun=1 and second row data presented; raise row_ready -> single handshake.
REQ-039 Bench: hub_oe_n low for 33 hub_clk periods at 4x ratio -> on_valid pulse with on_cycles=132 ±1; hub_clk toggled during oe low -> err_overlap=1.
REQ-040 Bench: rst_in asserted after 10 of 32 clocks, released, full 32-clock row then latch -> exactly one row_valid, no errors, row_top matches the second load only.
REQ-041 Bench: addr=20 with SCREEN_DEPTH=16 -> err_addr=1 and row_addr=20.
